mem_access_ctrl: RTL and testbench



---
 rtl/mem_ctrl_pkg.sv | 19 +
 rtl/mem_access_ctrl_if.sv | 35 +++
 rtl/mem_access_ctrl_burst_counter.sv | 45 ++++
 rtl/mem_access_ctrl.sv | 127 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: default widths,
// controller state encoding and request opcode values.
package mem_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between the datapath and the
// load/store controller.
//   master : datapath side  (drives req_*, rsp_ready)
//   slave  : controller side (drives req_ready, rsp_*)
interface mem_access_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W,
  parameter int LEN_W_P  = LEN_W
) ();

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [ADDR_W_P-1:0] req_addr;
  logic [DATA_W_P-1:0] req_wdata;
  logic [LEN_W_P-1:0]  req_len;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [DATA_W_P-1:0] rsp_rdata;
  logic                rsp_last;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_last
  );

endinterface

// File: rtl/mem_access_ctrl_burst_counter.sv
// Burst address/beat counter for the load/store controller.
//   clock, reset : clock, asynchronous active-high reset
//   load         : capture load_addr / load_len
//   load_addr    : starting address
//   load_len     : remaining beats minus one
//   step         : advance to next beat (address +1 wrapping, count -1)
//   addr         : current address
//   last         : current beat is the final one (count == 0)
module burst_counter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int LEN_W_P  = LEN_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic [ADDR_W_P-1:0] load_addr,
  input  logic [LEN_W_P-1:0]  load_len,
  input  logic                step,
  output logic [ADDR_W_P-1:0] addr,
  output logic                last
);

  logic [ADDR_W_P-1:0] addr_q;
  logic [LEN_W_P-1:0]  count_q;

  // Address wraps naturally modulo 2^ADDR_W_P.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      count_q <= '0;
    end else if (load) begin
      addr_q  <= load_addr;
      count_q <= load_len;
    end else if (step) begin
      addr_q  <= addr_q + 1'b1;
      count_q <= count_q - 1'b1;
    end
  end

  assign addr = addr_q;
  assign last = (count_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller in front of the data memory.
//   clock, reset : clock, asynchronous active-high reset
//   bus          : request/response handshake (slave side)
//   mem_write    : memory write strobe (only in WRITE)
//   mem_address  : memory address (always the current burst address)
//   mem_data     : memory write data (always the latched store data)
//   mem_out      : combinational memory read data
//   busy         : controller not in IDLE
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W,
  parameter int LEN_W_P  = LEN_W
) (
  input  logic                clock,
  input  logic                reset,
  mem_access_ctrl_if.slave    bus,
  output logic                mem_write,
  output logic [ADDR_W_P-1:0] mem_address,
  output logic [DATA_W_P-1:0] mem_data,
  input  logic [DATA_W_P-1:0] mem_out,
  output logic                busy
);

  state_e              state_q, state_d;
  logic [DATA_W_P-1:0] wdata_q;
  logic [DATA_W_P-1:0] rdata_q;

  logic                req_ready_d;
  logic                rsp_valid_d;
  logic                mem_write_d;
  logic                cnt_load;
  logic                cnt_step;
  logic [LEN_W_P-1:0]  cnt_len;
  logic [ADDR_W_P-1:0] cur_addr;
  logic                cur_last;

  // Stores are single-beat, so their length is forced to zero.
  assign cnt_len = (bus.req_write == OP_STORE) ? '0 : bus.req_len;

  burst_counter #(
    .ADDR_W_P (ADDR_W_P),
    .LEN_W_P  (LEN_W_P)
  ) u_burst_counter (
    .clock     (clock),
    .reset     (reset),
    .load      (cnt_load),
    .load_addr (bus.req_addr),
    .load_len  (cnt_len),
    .step      (cnt_step),
    .addr      (cur_addr),
    .last      (cur_last)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_d = 1'b0;
    rsp_valid_d = 1'b0;
    mem_write_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_step    = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_d = 1'b1;
        if (bus.req_valid) begin
          cnt_load = 1'b1;
          state_d  = (bus.req_write == OP_STORE) ? WRITE : READ;
        end
      end
      WRITE: begin
        mem_write_d = 1'b1;
        state_d     = RESP;
      end
      READ: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid_d = 1'b1;
        if (bus.rsp_ready) begin
          if (cur_last) begin
            state_d = IDLE;
          end else begin
            cnt_step = 1'b1;
            state_d  = READ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Store ack echoes the written data; loads capture the memory output.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (state_q == IDLE && bus.req_valid) begin
        wdata_q <= bus.req_wdata;
      end
      if (state_q == WRITE) begin
        rdata_q <= wdata_q;
      end else if (state_q == READ) begin
        rdata_q <= mem_out;
      end
    end
  end

  assign bus.req_ready = req_ready_d;
  assign bus.rsp_valid = rsp_valid_d;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_last  = rsp_valid_d & cur_last;
  assign mem_write     = mem_write_d;
  assign mem_address   = cur_addr;
  assign mem_data      = wdata_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mem_write;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic [7:0] mem_out;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  mem_access_ctrl_if bus ();

  mem_access_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .mem_write   (mem_write),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .mem_out     (mem_out),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  // Data memory: synchronous write, combinational read, table re-applied
  // every clock after the write so it always wins.
  logic [7:0] mem [256] = '{default: 8'h00};
  always @(posedge clock) begin
    if (mem_write) mem[mem_address] <= mem_data;
    mem[100] <= 8'd10;
    mem[101] <= 8'd7;
    mem[102] <= 8'd75;
    mem[103] <= 8'd9;
    mem[117] <= 8'd120;
    mem[118] <= 8'd1;
    mem[119] <= 8'd1;
    mem[120] <= 8'd1;
    mem[121] <= 8'd1;
  end
  assign mem_out = mem[mem_address];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one cycle; it must be accepted at that edge.
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                       input logic [3:0] len);
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_len   = len;
    chk("req_ready_before_accept", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    bus.req_addr  = 8'hEE;
    bus.req_len   = 4'hF;
    chk("busy_after_accept", busy, 1);
    chk("req_ready_after_accept", bus.req_ready, 0);
  endtask

  // Load burst with rsp_ready held high; each beat appears 2 cycles apart.
  task automatic load_burst(input logic [7:0] a, input logic [3:0] len,
                            input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    issue(1'b0, a, 8'h00, len);
    for (int i = 0; i <= int'(len); i++) begin
      chk("read_no_valid", bus.rsp_valid, 0);
      chk("read_no_write", mem_write, 0);
      chk("read_addr", mem_address, 8'(a + 8'(i)));
      tick();
      chk("beat_valid", bus.rsp_valid, 1);
      chk("beat_data", bus.rsp_rdata, exp[i]);
      chk("beat_last", bus.rsp_last, (i == int'(len)) ? 1 : 0);
      chk("beat_no_write", mem_write, 0);
      tick();
    end
    chk("idle_after_load", bus.req_ready, 1);
    chk("no_valid_after_load", bus.rsp_valid, 0);
  endtask

  task automatic store(input logic [7:0] a, input logic [7:0] wd);
    issue(1'b1, a, wd, 4'h7);
    chk("store_mem_write", mem_write, 1);
    chk("store_mem_addr", mem_address, a);
    chk("store_mem_data", mem_data, wd);
    tick();
    chk("store_write_one_cycle", mem_write, 0);
    chk("ack_valid", bus.rsp_valid, 1);
    chk("ack_data", bus.rsp_rdata, wd);
    chk("ack_last", bus.rsp_last, 1);
    tick();
    chk("idle_after_store", bus.req_ready, 1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_wdata = 8'h00;
    bus.req_len   = 4'h0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_last", bus.rsp_last, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data", mem_data, 0);
    reset = 1'b0;
    tick();

    // Single load, then burst of four.
    load_burst(8'd100, 4'd0, 8'd10, 8'd0, 8'd0, 8'd0);
    load_burst(8'd100, 4'd3, 8'd10, 8'd7, 8'd75, 8'd9);

    // Store then read-after-write.
    store(8'd20, 8'h5A);
    load_burst(8'd20, 4'd0, 8'h5A, 8'd0, 8'd0, 8'd0);

    // Backpressure on beat 0.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 8'd102, 8'h00, 4'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_data", bus.rsp_rdata, 8'd75);
      chk("bp_last", bus.rsp_last, 0);
      chk("bp_addr", mem_address, 8'd102);
      tick();
    end
    chk("bp_valid_held", bus.rsp_valid, 1);
    bus.rsp_ready = 1'b1;
    tick();
    chk("bp_read_addr", mem_address, 8'd103);
    chk("bp_read_no_valid", bus.rsp_valid, 0);
    tick();
    chk("bp_beat1_data", bus.rsp_rdata, 8'd9);
    chk("bp_beat1_last", bus.rsp_last, 1);
    tick();
    chk("bp_idle", bus.req_ready, 1);

    // Address wrap 255 -> 0.
    store(8'd255, 8'h11);
    store(8'd0, 8'h22);
    load_burst(8'd255, 4'd1, 8'h11, 8'h22, 8'd0, 8'd0);

    // Reset during RESP of a 4-beat burst.
    bus.rsp_ready = 1'b0;
    issue(1'b0, 8'd100, 8'h00, 4'd3);
    tick();
    chk("pre_rst_valid", bus.rsp_valid, 1);
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", bus.rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_mem_write", mem_write, 0);
    @(negedge clock);
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    #1;
    chk("postrst_req_ready", bus.req_ready, 1);
    chk("postrst_rsp_valid", bus.rsp_valid, 0);
    @(posedge clock);
    #1;
    load_burst(8'd101, 4'd0, 8'd7, 8'd0, 8'd0, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

endmodule
